// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one synchronous write port
// and a per-register busy scoreboard for RAW hazard detection.
module regfile_sb #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       ra1,
  input  logic [ADDR_W-1:0]       ra2,
  output logic [DATA_W-1:0]       rd1,
  output logic [DATA_W-1:0]       rd2,
  output logic                    busy1,
  output logic                    busy2,
  input  logic                    we3,
  input  logic [ADDR_W-1:0]       wa3,
  input  logic [DATA_W-1:0]       wd3,
  input  logic                    rsv_en,
  input  logic [ADDR_W-1:0]       rsv_a,
  output logic [(1<<ADDR_W)-1:0]  busy_vec
);

  localparam int unsigned N      = 1 << ADDR_W;
  localparam bit          ZR     = (ZERO_REG != 0);
  localparam bit          BYP    = (BYPASS != 0);

  logic [DATA_W-1:0] regs [N];
  logic [N-1:0]      busy_q;
  logic [N-1:0]      busy_nxt;
  logic              wr_ok;

  // Writes to the hardwired zero register are dropped.
  assign wr_ok = we3 && !(ZR && (wa3 == ADDR_W'(0)));

  // Reserve is applied after release so a same-register issue wins.
  always_comb begin
    busy_nxt = busy_q;
    if (we3)
      busy_nxt[wa3] = 1'b0;
    if (rsv_en)
      busy_nxt[rsv_a] = 1'b1;
    if (ZR)
      busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++)
        regs[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_ok)
        regs[wa3] <= wd3;
      busy_q <= busy_nxt;
    end
  end

  assign busy_vec = busy_q;

  // Read port 1: registered state, optional forwarding, zero-register mask.
  always_comb begin
    rd1   = regs[ra1];
    busy1 = busy_q[ra1];
    if (BYP && we3 && (wa3 == ra1)) begin
      rd1   = wd3;
      busy1 = 1'b0;
    end
    if (ZR && (ra1 == ADDR_W'(0))) begin
      rd1   = '0;
      busy1 = 1'b0;
    end
  end

  // Read port 2: identical to port 1.
  always_comb begin
    rd2   = regs[ra2];
    busy2 = busy_q[ra2];
    if (BYP && we3 && (wa3 == ra2)) begin
      rd2   = wd3;
      busy2 = 1'b0;
    end
    if (ZR && (ra2 == ADDR_W'(0))) begin
      rd2   = '0;
      busy2 = 1'b0;
    end
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-register file for the datapath: two combinational read ports and one synchronous write port.
- Register 0 is optionally hardwired to zero.
- Optional write-to-read bypass.
- Per-register busy scoreboard: the issue stage reserves a destination register and writeback releases it, so the control FSM can detect RAW hazards before reading operands.

Parameters:
- DATA_W, 8, width of each register and of the data ports.
- ADDR_W, 3, address width; depth N = 2**ADDR_W registers.
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports and clears the reported busy flag.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- ra1  input  ADDR_W  read address, port 1.
- ra2  input  ADDR_W  read address, port 2.
- rd1  output  DATA_W  read data, port 1 (combinational).
- rd2  output  DATA_W  read data, port 2 (combinational).
- busy1  output  1  register at ra1 has a pending writeback.
- busy2  output  1  register at ra2 has a pending writeback.
- we3  input  1  write enable.
- wa3  input  ADDR_W  write address.
- wd3  input  DATA_W  write data.
- rsv_en  input  1  reserve destination register (issue).
- rsv_a  input  ADDR_W  register to reserve.
- busy_vec  output  N  registered busy bit per register, bit i = register i.

Behaviour:
- Reset:
  - rst high at a rising clk edge clears all N registers to 0 and busy_vec to 0.
  - rst has priority over we3 and rsv_en in that cycle.
  - After the reset edge, rd1 = rd2 = 0, busy1 = busy2 = 0 and busy_vec = 0 for every address, until a write occurs.
  - Reset asserted mid-operation discards all pending reservations.
- Write:
  - On a rising edge with we3 = 1 and rst = 0, reg[wa3] <= wd3 and busy[wa3] <= 0.
  - The new value is visible on rd* one cycle later (zero-cycle read-after-write only through the bypass).
- Reserve:
  - On a rising edge with rsv_en = 1 and rst = 0, busy[rsv_a] <= 1.
  - Register data is not changed.
- Same register written and reserved in one cycle (we3 && rsv_en && wa3 == rsv_a): reserve wins, so busy stays/becomes 1 and the data is still written. This models the old producer retiring while a new one issues.
- Different register written and reserved: both updates apply.
- Reserving an already-busy register: no change (remains 1). No counting, single outstanding producer per register.
- Writing a non-busy register: data written, busy remains 0.
- ZERO_REG = 1:
  - Writes to address 0 are ignored.
  - Reserves of address 0 are ignored.
  - busy_vec[0] is constant 0.
  - A read of address 0 returns 0 regardless of bypass.
- ZERO_REG = 0: register 0 is ordinary.
- Read port x (x = 1 or 2, address rax):
  - Base value: rdx = reg[rax], busyx = busy_vec[rax].
  - BYPASS = 1 and we3 = 1 and wa3 == rax (and not the zero register): rdx = wd3 and busyx = 0 in the same cycle.
  - BYPASS = 0: no forwarding; rdx and busyx come from registered state only.
  - Bypass is not gated by rst (reads are combinational).
- Both read ports are fully independent; ra1 == ra2 returns identical data and flags.
- No other latency: reads are combinational, writes and reservations take effect at the next edge.

Test Plan:
- Reset, then sweep ra1/ra2 over all 8 addresses -> rd1 = rd2 = 0 and busy_vec = 8'h00 throughout.
- we3=1, wa3=5, wd3=8'hA5 for one edge, then ra1=5, ra2=5 -> rd1 = rd2 = 8'hA5. Then we3=1, wa3=0, wd3=8'hFF, ra1=0 -> rd1 = 0 and busy_vec[0] = 0 (ZERO_REG=1).
- BYPASS=1: with reg3=8'h11, drive we3=1, wa3=3, wd3=8'h22 with ra2=3, sampled before the edge -> rd2 = 8'h22 combinationally. Repeat with BYPASS=0 -> rd2 = 8'h11 until after the edge.
- rsv_en=1, rsv_a=4 -> busy_vec = 8'h10 next cycle and busy1=1 at ra1=4. Then we3=1, wa3=4, wd3=8'h3C -> with BYPASS=1, busy1=0 and rd1=8'h3C in the same cycle; busy_vec = 8'h00 after the edge.
- With reg6 busy, apply we3=1, wa3=6, rsv_en=1, rsv_a=6, wd3=8'h77 on the same edge -> reg6=8'h77 and busy_vec[6] stays 1. Same edge with rsv_a=2 instead -> busy_vec[6]=0, busy_vec[2]=1.
- Reserve regs 1, 2 and 7, write reg7=8'h99, then assert rst with we3=1, wa3=1, wd3=8'hEE on the same edge -> all registers read 0 and busy_vec=8'h00 after the edge; the write is discarded.
